// File: rtl/alu_seq.sv
// alu_seq: Forth stack ALU with the single-cycle primitives plus iterative
// double-width multiply and divide/modulo behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             c_YCLOCK,
  input  logic             c_RESET,
  input  logic [WIDTH-1:0] i_OP1,
  input  logic [WIDTH-1:0] i_OP2,
  input  logic [4:0]       f_aluctrl,
  input  logic             i_START,
  output logic             o_BUSY,
  output logic             o_DONE,
  output logic [WIDTH-1:0] o_RESULT,
  output logic [WIDTH-1:0] o_RESULT_HI,
  output logic             o_DIVZERO
);

  localparam int               CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
  localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};

  localparam logic [4:0] OP_UMUL = 5'h10;
  localparam logic [4:0] OP_MMUL = 5'h11;
  localparam logic [4:0] OP_UDIV = 5'h12;
  localparam logic [4:0] OP_SDIV = 5'h13;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] opnd_r;
  logic             signed_r;
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_r_r;

  logic [WIDTH-1:0]   abs1_s;
  logic [WIDTH-1:0]   abs2_s;
  logic [WIDTH-1:0]   alu_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] prod_neg_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    abs_val = v[WIDTH-1] ? (ZERO - v) : v;
  endfunction

  assign abs1_s = abs_val(i_OP1);
  assign abs2_s = abs_val(i_OP2);

  // Single-cycle primitives; shift amount is |TOS| so the most negative value shifts everything out
  always_comb begin
    alu_s = ZERO;
    case (f_aluctrl[3:0])
      4'h0:    alu_s = (i_OP1 == ZERO) ? ALL_ONES : ZERO;
      4'h1:    alu_s = abs1_s;
      4'h2:    alu_s = ZERO - i_OP1;
      4'h3:    alu_s = ~i_OP1;
      4'h4:    alu_s = i_OP2 + i_OP1;
      4'h5:    alu_s = i_OP2 - i_OP1;
      4'h6:    alu_s = i_OP2 * i_OP1;
      4'h7:    alu_s = (abs1_s >= WIDTH_VAL) ? ZERO : (i_OP2 << abs1_s);
      4'h8:    alu_s = (abs1_s >= WIDTH_VAL) ? ZERO : (i_OP2 >> abs1_s);
      4'h9:    alu_s = i_OP2 & i_OP1;
      4'hA:    alu_s = i_OP2 | i_OP1;
      4'hB:    alu_s = i_OP2 ^ i_OP1;
      4'hC:    alu_s = ($signed(i_OP2) <  $signed(i_OP1)) ? ALL_ONES : ZERO;
      4'hD:    alu_s = ($signed(i_OP2) <= $signed(i_OP1)) ? ALL_ONES : ZERO;
      4'hE:    alu_s = (i_OP2 == i_OP1) ? ALL_ONES : ZERO;
      4'hF:    alu_s = (i_OP2 != i_OP1) ? ALL_ONES : ZERO;
      default: alu_s = ZERO;
    endcase
  end

  // Iteration step and sign fix-up; {hi,lo} holds the product, or remainder/quotient for divides
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO});
    div_shift_s = {hi_r, lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    prod_neg_s  = {ZERO, ZERO} - {hi_r, lo_r};
    if (is_div_r) begin
      fix_lo_s = neg_q_r ? (ZERO - lo_r) : lo_r;
      fix_hi_s = neg_r_r ? (ZERO - hi_r) : hi_r;
    end else begin
      fix_lo_s = neg_q_r ? prod_neg_s[WIDTH-1:0] : lo_r;
      fix_hi_s = neg_q_r ? prod_neg_s[2*WIDTH-1:WIDTH] : hi_r;
    end
  end

  // Control FSM, iteration registers and registered outputs
  always_ff @(negedge c_YCLOCK) begin
    if (c_RESET) begin
      state_r     <= S_IDLE;
      cnt_r       <= CNT_ZERO;
      hi_r        <= ZERO;
      lo_r        <= ZERO;
      opnd_r      <= ZERO;
      signed_r    <= 1'b0;
      is_div_r    <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      o_BUSY      <= 1'b0;
      o_DONE      <= 1'b0;
      o_RESULT    <= ZERO;
      o_RESULT_HI <= ZERO;
      o_DIVZERO   <= 1'b0;
    end else begin
      o_DONE <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (i_START) begin
            o_DIVZERO <= 1'b0;
            cnt_r     <= CNT_ZERO;
            hi_r      <= ZERO;
            case (f_aluctrl)
              OP_UMUL, OP_MMUL: begin
                signed_r <= (f_aluctrl == OP_MMUL);
                is_div_r <= 1'b0;
                neg_r_r  <= 1'b0;
                neg_q_r  <= (f_aluctrl == OP_MMUL) && (i_OP1[WIDTH-1] ^ i_OP2[WIDTH-1]);
                lo_r     <= (f_aluctrl == OP_MMUL) ? abs1_s : i_OP1;
                opnd_r   <= (f_aluctrl == OP_MMUL) ? abs2_s : i_OP2;
                o_BUSY   <= 1'b1;
                state_r  <= S_MUL;
              end
              OP_UDIV, OP_SDIV: begin
                if (i_OP1 == ZERO) begin
                  o_RESULT    <= ALL_ONES;
                  o_RESULT_HI <= i_OP2;
                  o_DIVZERO   <= 1'b1;
                  o_DONE      <= 1'b1;
                end else begin
                  signed_r <= (f_aluctrl == OP_SDIV);
                  is_div_r <= 1'b1;
                  neg_q_r  <= (f_aluctrl == OP_SDIV) && (i_OP1[WIDTH-1] ^ i_OP2[WIDTH-1]);
                  neg_r_r  <= (f_aluctrl == OP_SDIV) && i_OP2[WIDTH-1];
                  lo_r     <= (f_aluctrl == OP_SDIV) ? abs2_s : i_OP2;
                  opnd_r   <= (f_aluctrl == OP_SDIV) ? abs1_s : i_OP1;
                  o_BUSY   <= 1'b1;
                  state_r  <= S_DIV;
                end
              end
              default: begin
                o_RESULT    <= f_aluctrl[4] ? ZERO : alu_s;
                o_RESULT_HI <= ZERO;
                o_DONE      <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          hi_r  <= mul_sum_s[WIDTH:1];
          lo_r  <= {mul_sum_s[0], lo_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            o_BUSY  <= signed_r;
            state_r <= signed_r ? S_FIX : S_DONE;
          end
        end
        S_DIV: begin
          if (!div_diff_s[WIDTH]) begin
            hi_r <= div_diff_s[WIDTH-1:0];
            lo_r <= {lo_r[WIDTH-2:0], 1'b1};
          end else begin
            hi_r <= div_shift_s[WIDTH-1:0];
            lo_r <= {lo_r[WIDTH-2:0], 1'b0};
          end
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            o_BUSY  <= signed_r;
            state_r <= signed_r ? S_FIX : S_DONE;
          end
        end
        S_FIX: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          o_BUSY  <= 1'b0;
          state_r <= S_DONE;
        end
        S_DONE: begin
          o_RESULT    <= lo_r;
          o_RESULT_HI <= hi_r;
          o_DONE      <= 1'b1;
          state_r     <= S_IDLE;
        end
        default: begin
          o_BUSY  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the single-cycle stack ALU in the Forth core datapath. It keeps the 16 single-cycle Forth primitives at the same opcodes and adds iterative double-width multiply and divide/modulo. Operands arrive from the data stack (TOS, NOS), and a start/busy/done handshake lets the control sequencer stall while multi-cycle operations run. The second result word (high product or remainder) is returned for pushing back onto the stack.

## Interface
- WIDTH, 16: data width in bits; must be ≥ 4.
- c_YCLOCK  in  1  clock; all state updates on its falling edge.
- c_RESET  in  1  synchronous, active-high reset, sampled on the falling edge of c_YCLOCK.
- i_OP1  in  WIDTH  top of stack.
- i_OP2  in  WIDTH  second stack element.
- f_aluctrl  in  5  opcode.
- i_START  in  1  request; accepted only when o_BUSY=0.
- o_BUSY  out  1  multi-cycle operation in progress.
- o_DONE  out  1  one-cycle pulse when results are valid.
- o_RESULT  out  WIDTH  primary result: low product word or quotient.
- o_RESULT_HI  out  WIDTH  secondary result: high product word or remainder. It is 0 for single-width ops.
- o_DIVZERO  out  1  the last divide had a zero divisor. Held until the next accepted start.

## Operation
- Opcodes 0x00–0x0F are single-cycle:
  - 0=, ABS, NEGATE, INVERT, +, -, *(low WIDTH), LSHIFT, RSHIFT, AND, OR, XOR, <, <=, =, <>.
  - All are signed, with result = NOS op TOS.
  - True flag is all-ones; false is 0.
  - Shift amount = |OP1|. An amount ≥ WIDTH yields 0. RSHIFT is logical.
- Multi-cycle opcodes:
  - 0x10 UM* (unsigned double product).
  - 0x11 M* (signed double product).
  - 0x12 U/MOD (unsigned OP2÷OP1).
  - 0x13 /MOD (signed, truncated toward zero; remainder takes the dividend's sign).
- Opcodes 0x14–0x1F are reserved: both results 0, single-cycle.
- Operands and opcode are latched on acceptance. Input changes while busy are ignored.
- States and transitions:
  - IDLE: on accept, single-cycle ops → result, stay IDLE. UM*/M* → MUL. U/MOD and /MOD with nonzero divisor → DIV. Zero divisor → immediate result, stay IDLE.
  - MUL: shift-add over exactly WIDTH iterations, using the absolute values of the operands for M*.
  - DIV: restoring division over exactly WIDTH iterations, using absolute values for /MOD.
  - MUL/DIV exit: unsigned ops → DONE. Signed ops → FIX.
  - FIX: one cycle. Negate the 2·WIDTH product if the operand signs differ. Negate the quotient if the signs differ. Negate the remainder if the dividend is negative.
  - DONE: results written, o_DONE=1, then → IDLE.
- Divide by zero (either divide op):
  - o_RESULT = all-ones, o_RESULT_HI = OP2, o_DIVZERO = 1.
  - Single-cycle latency.
- o_RESULT and o_RESULT_HI hold their last values between operations. Internal iteration values are never visible on them.
- i_START with o_BUSY=1 is ignored and not queued.

## Timing
- Reset: o_RESULT=0, o_RESULT_HI=0, o_BUSY=0, o_DONE=0, o_DIVZERO=0, state IDLE.
- Reset asserted mid-operation aborts the operation. There is no o_DONE for the aborted op. Reset has priority over i_START on the same edge.
- In all cases below, the start is accepted at edge N.
- Single-cycle and reserved ops, and divide by zero:
  - Results and o_DONE=1 appear after edge N.
  - o_BUSY stays 0.
- Unsigned multi-cycle ops:
  - o_BUSY=1 after edge N through edge N+WIDTH.
  - Results and o_DONE=1 appear after edge N+WIDTH+1, with o_BUSY=0 at the same time.
  - Latency is WIDTH+1.
- Signed multi-cycle ops:
  - One extra FIX cycle: latency WIDTH+2, with o_BUSY high for WIDTH+1 cycles.
- Back-to-back: a start presented while o_DONE=1 (o_BUSY=0) is accepted on that edge.
- o_DONE is a single-cycle pulse. Consecutive single-cycle ops give consecutive pulses.
- o_DIVZERO clears on the next accepted start.

## Test plan
- + with OP2=0x7FFF, OP1=0x0001 → o_RESULT=0x8000 and o_RESULT_HI=0 after 1 edge, o_DONE 1 cycle, o_BUSY never high.
- UM* with 0xFFFF×0xFFFF → o_RESULT_HI=0xFFFE, o_RESULT=0x0001 after 17 edges; o_BUSY high exactly 16 cycles; operands toggled mid-op leave the result unchanged.
- /MOD with OP2=0xFFF9 (−7), OP1=0x0002 → quotient 0xFFFD (−3), remainder 0xFFFF (−1) after 18 edges. M* with −3×5 → HI=0xFFFF, LO=0xFFF1.
- U/MOD with OP2=0x1234, OP1=0 → o_RESULT=0xFFFF, o_RESULT_HI=0x1234, o_DIVZERO=1 after 1 edge. The next valid op clears o_DIVZERO.
- LSHIFT with OP2=0x0001, OP1=0xFFFD (−3) → 0x0008. LSHIFT by 16 → 0x0000. RSHIFT with OP2=0x8000, OP1=15 → 0x0001.
- Start UM*, assert i_START again at cycle 3 (ignored), assert c_RESET at cycle 5 → all outputs 0 next edge, no o_DONE. A new + start then completes normally.
